// File: rtl/rbfu_out_xbar_if.sv
// Bundle of control, data and result signals between the RBFU result
// crossbar and its surroundings; the crossbar uses the slave view.
interface rbfu_out_xbar_if #(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 12,
    parameter int SEL_W   = 2
);
    logic                        sel_valid;
    logic [N_LANES*SEL_W-1:0]    sel_BI_bus;
    logic [N_LANES-1:0]          lane_mask;
    logic                        mode_bypass;
    logic [N_LANES*DATA_W-1:0]   bf_out_bus;
    logic                        err_clr;
    logic [N_LANES*DATA_W-1:0]   d_in_bus;
    logic                        d_in_valid;
    logic [N_LANES-1:0]          d_in_we;
    logic                        sel_err;

    modport master (
        output sel_valid, sel_BI_bus, lane_mask, mode_bypass, bf_out_bus, err_clr,
        input  d_in_bus, d_in_valid, d_in_we, sel_err
    );

    modport slave (
        input  sel_valid, sel_BI_bus, lane_mask, mode_bypass, bf_out_bus, err_clr,
        output d_in_bus, d_in_valid, d_in_we, sel_err
    );
endinterface

// File: rtl/rbfu_out_xbar.sv
// Gather crossbar from butterfly result lanes to bank write ports. Control
// words are delayed SEL_DELAY cycles to meet their butterfly data.
module rbfu_out_xbar #(
    parameter int N_LANES   = 4,
    parameter int DATA_W    = 12,
    parameter int SEL_W     = 2,
    parameter int SEL_DELAY = 4
) (
    input logic           clk,
    input logic           rst,
    rbfu_out_xbar_if.slave xb
);

    // Aligned control word as seen together with the current bf_out_bus.
    logic                        al_valid_s;
    logic [N_LANES*SEL_W-1:0]    al_sel_s;
    logic [N_LANES-1:0]          al_mask_s;
    logic                        al_bypass_s;

    logic [N_LANES*DATA_W-1:0]   route_bus_s;
    logic [N_LANES-1:0]          route_we_s;
    logic                        err_set_s;
    logic [SEL_W-1:0]            lane_sel_s;
    logic                        lane_ok_s;

    logic [N_LANES*DATA_W-1:0]   d_in_bus_r;
    logic                        d_in_valid_r;
    logic [N_LANES-1:0]          d_in_we_r;
    logic                        sel_err_r;

    function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
        return (32'(s) < 32'(N_LANES));
    endfunction

    // Loop-based mux keeps out-of-range codes from indexing past the bus.
    function automatic logic [DATA_W-1:0] pick_lane(
        input logic [N_LANES*DATA_W-1:0] src,
        input logic [SEL_W-1:0]          s
    );
        logic [DATA_W-1:0] res;
        res = {DATA_W{1'b0}};
        for (int i = 0; i < N_LANES; i++) begin
            res = (s == SEL_W'(i)) ? src[i*DATA_W +: DATA_W] : res;
        end
        return res;
    endfunction

    generate
        if (SEL_DELAY == 0) begin : g_nodly
            assign al_valid_s  = xb.sel_valid;
            assign al_sel_s    = xb.sel_BI_bus;
            assign al_mask_s   = xb.lane_mask;
            assign al_bypass_s = xb.mode_bypass;
        end else begin : g_dly
            logic                     pipe_valid_r  [SEL_DELAY];
            logic [N_LANES*SEL_W-1:0] pipe_sel_r    [SEL_DELAY];
            logic [N_LANES-1:0]       pipe_mask_r   [SEL_DELAY];
            logic                     pipe_bypass_r [SEL_DELAY];

            // Control shift pipe; reset flushes every in-flight word.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < SEL_DELAY; k++) begin
                        pipe_valid_r[k]  <= 1'b0;
                        pipe_sel_r[k]    <= '0;
                        pipe_mask_r[k]   <= '0;
                        pipe_bypass_r[k] <= 1'b0;
                    end
                end else begin
                    pipe_valid_r[0]  <= xb.sel_valid;
                    pipe_sel_r[0]    <= xb.sel_BI_bus;
                    pipe_mask_r[0]   <= xb.lane_mask;
                    pipe_bypass_r[0] <= xb.mode_bypass;
                    for (int k = 1; k < SEL_DELAY; k++) begin
                        pipe_valid_r[k]  <= pipe_valid_r[k-1];
                        pipe_sel_r[k]    <= pipe_sel_r[k-1];
                        pipe_mask_r[k]   <= pipe_mask_r[k-1];
                        pipe_bypass_r[k] <= pipe_bypass_r[k-1];
                    end
                end
            end

            assign al_valid_s  = pipe_valid_r[SEL_DELAY-1];
            assign al_sel_s    = pipe_sel_r[SEL_DELAY-1];
            assign al_mask_s   = pipe_mask_r[SEL_DELAY-1];
            assign al_bypass_s = pipe_bypass_r[SEL_DELAY-1];
        end
    endgenerate

    // Per-lane routing, write enables and out-of-range detection.
    always_comb begin
        route_bus_s = '0;
        route_we_s  = '0;
        err_set_s   = 1'b0;
        lane_sel_s  = '0;
        lane_ok_s   = 1'b0;
        for (int j = 0; j < N_LANES; j++) begin
            lane_sel_s = al_sel_s[j*SEL_W +: SEL_W];
            if (al_bypass_s) begin
                route_bus_s[j*DATA_W +: DATA_W] = xb.bf_out_bus[j*DATA_W +: DATA_W];
                lane_ok_s = 1'b1;
            end else if (sel_in_range(lane_sel_s)) begin
                route_bus_s[j*DATA_W +: DATA_W] = pick_lane(xb.bf_out_bus, lane_sel_s);
                lane_ok_s = 1'b1;
            end else begin
                route_bus_s[j*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                lane_ok_s = 1'b0;
            end
            route_we_s[j] = al_valid_s & al_mask_s[j] & lane_ok_s;
            // Only lanes that would really be written can raise the error.
            if (al_valid_s && al_mask_s[j] && !lane_ok_s) begin
                err_set_s = 1'b1;
            end else begin
                err_set_s = err_set_s;
            end
        end
    end

    // Output register; data holds when no aligned word is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_in_bus_r   <= '0;
            d_in_valid_r <= 1'b0;
            d_in_we_r    <= '0;
        end else if (al_valid_s) begin
            d_in_bus_r   <= route_bus_s;
            d_in_valid_r <= 1'b1;
            d_in_we_r    <= route_we_s;
        end else begin
            d_in_bus_r   <= d_in_bus_r;
            d_in_valid_r <= 1'b0;
            d_in_we_r    <= '0;
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_err_r <= 1'b0;
        end else if (err_set_s) begin
            sel_err_r <= 1'b1;
        end else if (xb.err_clr) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign xb.d_in_bus   = d_in_bus_r;
    assign xb.d_in_valid = d_in_valid_r;
    assign xb.d_in_we    = d_in_we_r;
    assign xb.sel_err    = sel_err_r;

endmodule

// File: tb/tb_rbfu_out_xbar.sv
// Scoreboard bench for rbfu_out_xbar: three instances (N=4/D=4, N=4/D=0,
// N=3/D=2) driven from shared directed tables, one active at a time.
module tb_rbfu_out_xbar;

    typedef struct {
        logic [47:0] bus;
        logic [3:0]  we;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          act = 0;
    int          n_chk = 0;
    int          n_err = 0;
    exp_t        q[$];

    logic        drv_valid = 1'b0;
    logic [7:0]  drv_sel   = '0;
    logic [3:0]  drv_mask  = '0;
    logic        drv_byp   = 1'b0;
    logic [47:0] drv_bf    = '0;
    logic        drv_clr   = 1'b0;

    logic [47:0] m_bus;
    logic        m_valid;
    logic [3:0]  m_we;
    logic        m_err;

    logic        v_valid [16];
    logic [7:0]  v_sel   [16];
    logic [3:0]  v_mask  [16];
    logic        v_byp   [16];
    logic [47:0] v_bf    [16];
    logic        v_clr   [16];
    logic [47:0] e_bus   [16];
    logic [3:0]  e_we    [16];
    logic        e_err   [16];

    rbfu_out_xbar_if #(.N_LANES(4), .DATA_W(12), .SEL_W(2)) if_a();
    rbfu_out_xbar_if #(.N_LANES(4), .DATA_W(12), .SEL_W(2)) if_b();
    rbfu_out_xbar_if #(.N_LANES(3), .DATA_W(12), .SEL_W(2)) if_c();

    rbfu_out_xbar #(.N_LANES(4), .DATA_W(12), .SEL_W(2), .SEL_DELAY(4))
        dut_a (.clk(clk), .rst(rst), .xb(if_a));
    rbfu_out_xbar #(.N_LANES(4), .DATA_W(12), .SEL_W(2), .SEL_DELAY(0))
        dut_b (.clk(clk), .rst(rst), .xb(if_b));
    rbfu_out_xbar #(.N_LANES(3), .DATA_W(12), .SEL_W(2), .SEL_DELAY(2))
        dut_c (.clk(clk), .rst(rst), .xb(if_c));

    assign if_a.sel_valid   = drv_valid && (act == 0);
    assign if_a.sel_BI_bus  = drv_sel;
    assign if_a.lane_mask   = drv_mask;
    assign if_a.mode_bypass = drv_byp;
    assign if_a.bf_out_bus  = drv_bf;
    assign if_a.err_clr     = drv_clr;
    assign if_b.sel_valid   = drv_valid && (act == 1);
    assign if_b.sel_BI_bus  = drv_sel;
    assign if_b.lane_mask   = drv_mask;
    assign if_b.mode_bypass = drv_byp;
    assign if_b.bf_out_bus  = drv_bf;
    assign if_b.err_clr     = drv_clr;
    assign if_c.sel_valid   = drv_valid && (act == 2);
    assign if_c.sel_BI_bus  = drv_sel[5:0];
    assign if_c.lane_mask   = drv_mask[2:0];
    assign if_c.mode_bypass = drv_byp;
    assign if_c.bf_out_bus  = drv_bf[35:0];
    assign if_c.err_clr     = drv_clr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        m_bus = '0; m_valid = 1'b0; m_we = '0; m_err = 1'b0;
        case (act)
            0: begin m_bus = if_a.d_in_bus; m_valid = if_a.d_in_valid; m_we = if_a.d_in_we; m_err = if_a.sel_err; end
            1: begin m_bus = if_b.d_in_bus; m_valid = if_b.d_in_valid; m_we = if_b.d_in_we; m_err = if_b.sel_err; end
            default: begin
                m_bus = {12'd0, if_c.d_in_bus}; m_valid = if_c.d_in_valid;
                m_we = {1'b0, if_c.d_in_we}; m_err = if_c.sel_err;
            end
        endcase
    end

    function automatic int dly(input int k);
        case (k)
            0: return 4;
            1: return 0;
            default: return 2;
        endcase
    endfunction

    function automatic logic [47:0] pk4(input int a3, input int a2, input int a1, input int a0);
        return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
    endfunction

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 16; i++) begin
            v_valid[i] = 1'b0; v_sel[i] = '0; v_mask[i] = '0; v_byp[i] = 1'b0;
            v_bf[i] = '0; v_clr[i] = 1'b0; e_bus[i] = '0; e_we[i] = '0; e_err[i] = 1'b0;
        end
    endtask

    task automatic setw(input int i, input logic vld, input logic [7:0] s, input logic [3:0] m,
                        input logic b, input logic [47:0] bf, input logic [47:0] eb,
                        input logic [3:0] ew, input logic ee);
        v_valid[i] = vld; v_sel[i] = s; v_mask[i] = m; v_byp[i] = b;
        v_bf[i] = bf; e_bus[i] = eb; e_we[i] = ew; e_err[i] = ee;
    endtask

    // Eight permutations, per-word data offset 16*w so misalignment shows.
    task automatic load_stream();
        clear_tab();
        setw(0, 1'b1, 8'hE4, 4'hF, 1'b0, pk4(5,6,7,8),         pk4(5,6,7,8),         4'hF, 1'b0);
        setw(1, 1'b1, 8'h1B, 4'hF, 1'b0, pk4(21,22,23,24),     pk4(24,23,22,21),     4'hF, 1'b0);
        setw(2, 1'b1, 8'h4E, 4'hF, 1'b0, pk4(37,38,39,40),     pk4(39,40,37,38),     4'hF, 1'b0);
        setw(3, 1'b1, 8'hB1, 4'hF, 1'b0, pk4(53,54,55,56),     pk4(54,53,56,55),     4'hF, 1'b0);
        setw(4, 1'b1, 8'h39, 4'hF, 1'b0, pk4(69,70,71,72),     pk4(72,69,70,71),     4'hF, 1'b0);
        setw(5, 1'b1, 8'h93, 4'hF, 1'b0, pk4(85,86,87,88),     pk4(86,87,88,85),     4'hF, 1'b0);
        setw(6, 1'b1, 8'hD8, 4'hF, 1'b0, pk4(101,102,103,104), pk4(101,103,102,104), 4'hF, 1'b0);
        setw(7, 1'b1, 8'h72, 4'hF, 1'b0, pk4(117,118,119,120), pk4(119,117,120,118), 4'hF, 1'b0);
    endtask

    task automatic switch_dut(input int k);
        @(posedge clk); #1;
        rst = 1'b0; drv_valid = 1'b0; drv_clr = 1'b0;
        act = k;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Step engine: word c's control at step c, its data at step c+D.
    task automatic run_test(input int n, input int rst_step);
        int  d;
        bit  killed;
        exp_t e;
        d = dly(act);
        killed = 1'b0;
        for (int c = 0; c < n + d + 3; c++) begin
            @(posedge clk); #1;
            if (killed && c == rst_step + 3) rst = 1'b1;
            if (c < n && !(killed && rst)) begin
                drv_valid = v_valid[c]; drv_sel = v_sel[c]; drv_mask = v_mask[c]; drv_byp = v_byp[c];
            end else begin
                drv_valid = 1'b0;
            end
            drv_bf  = (c - d >= 0 && c - d < n) ? v_bf[c-d] : 48'd0;
            drv_clr = (c < 16) ? v_clr[c] : 1'b0;
            if (c < n && v_valid[c] && rst && !killed) begin
                e.bus = e_bus[c]; e.we = e_we[c]; e.err = e_err[c]; e.cyc = cyc + d + 1;
                q.push_back(e);
            end
            if (c == rst_step) begin
                @(negedge clk); #1;
                rst = 1'b0;
                killed = 1'b1;
                #1;
                chk("rst_now_bus", m_bus, 48'd0);
                chk("rst_now_valid", {47'd0, m_valid}, 48'd0);
                chk("rst_now_we", {44'd0, m_we}, 48'd0);
                q.delete();
            end
        end
        drv_valid = 1'b0; drv_clr = 1'b0;
        @(negedge clk);
        chk("drained", 48'(q.size()), 48'd0);
        q.delete();
    endtask

    // Monitor: pops expected words on valid, checks hold/idle otherwise.
    initial begin
        exp_t        e;
        logic [47:0] last_bus;
        last_bus = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_bus", m_bus, 48'd0);
                chk("rst_valid", {47'd0, m_valid}, 48'd0);
                chk("rst_we", {44'd0, m_we}, 48'd0);
                chk("rst_err", {47'd0, m_err}, 48'd0);
                last_bus = '0;
            end else if (m_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {47'd0, m_valid}, 48'd0);
                    last_bus = m_bus;
                end else begin
                    e = q.pop_front();
                    chk("bus", m_bus, e.bus);
                    chk("we", {44'd0, m_we}, {44'd0, e.we});
                    chk("err", {47'd0, m_err}, {47'd0, e.err});
                    chk("latency_cycle", 48'(cyc), 48'(e.cyc));
                    last_bus = e.bus;
                end
            end else begin
                chk("idle_we", {44'd0, m_we}, 48'd0);
                chk("idle_hold_bus", m_bus, last_bus);
            end
        end
    end

    initial begin
        // Reset held with random traffic, then idle after release.
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drv_valid = 1'b1; drv_sel = 8'($urandom); drv_mask = 4'($urandom);
            drv_byp = 1'($urandom_range(0, 1)); drv_bf = {16'($urandom), 32'($urandom)};
            drv_clr = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        drv_valid = 1'b0; drv_clr = 1'b0;
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // N=4, D=4: permute, broadcast+mask, idle hole, bypass, swap.
        clear_tab();
        setw(0, 1'b1, 8'h1B, 4'hF, 1'b0, pk4(40,30,20,10),     pk4(10,20,30,40),     4'hF, 1'b0);
        setw(1, 1'b1, 8'hAA, 4'h5, 1'b0, pk4(4,77,2,1),        pk4(77,77,77,77),     4'h5, 1'b0);
        setw(2, 1'b0, 8'h1B, 4'hF, 1'b0, pk4(9,9,9,9),         48'd0,                4'h0, 1'b0);
        setw(3, 1'b1, 8'h00, 4'hF, 1'b1, pk4(100,200,300,400), pk4(100,200,300,400), 4'hF, 1'b0);
        setw(4, 1'b1, 8'hFF, 4'h3, 1'b1, pk4(11,22,33,44),     pk4(11,22,33,44),     4'h3, 1'b0);
        setw(5, 1'b1, 8'h4E, 4'hF, 1'b0, pk4(5,6,7,8),         pk4(7,8,5,6),         4'hF, 1'b0);
        run_test(6, -1);

        // Streams with reset during the third output, D=4 then D=0.
        load_stream();
        run_test(8, dly(0) + 3);
        switch_dut(1);
        load_stream();
        run_test(8, dly(1) + 3);

        // N=3, D=2: bypass, masked-out bad lane, bad lanes, set beats clear.
        switch_dut(2);
        clear_tab();
        setw(0, 1'b1, 8'h3F, 4'h7, 1'b1, pk4(0,7,8,9),    pk4(0,7,8,9),   4'h7, 1'b0);
        setw(1, 1'b1, 8'h0C, 4'h5, 1'b0, pk4(0,30,20,10), pk4(0,10,0,10), 4'h5, 1'b0);
        setw(2, 1'b1, 8'h2C, 4'h7, 1'b0, pk4(0,30,20,10), pk4(0,30,0,10), 4'h5, 1'b1);
        setw(3, 1'b1, 8'h13, 4'h7, 1'b0, pk4(0,3,2,1),    pk4(0,2,1,0),   4'h6, 1'b1);
        v_clr[5] = 1'b1;
        run_test(4, -1);
        chk("err_sticky", {47'd0, m_err}, 48'd1);
        @(posedge clk); #1 drv_clr = 1'b1;
        @(posedge clk); #1 drv_clr = 1'b0;
        @(negedge clk);
        chk("err_clr_alone", {47'd0, m_err}, 48'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
